// File: rtl/prim_intr_target_pkg.sv
// +--------------------------------------------------------------------+
// | prim_intr_target_pkg: shared ID helpers and trigger-mode encoding   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package prim_intr_target_pkg;

  localparam int ID_NONE = 0;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

  // ID 0 is reserved, so NumSrc sources need NumSrc+1 codes.
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prim_intr_gateway.sv
// +--------------------------------------------------------------------+
// | prim_intr_gateway: per-source pending/in-service tracking           |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module prim_intr_gateway
  import prim_intr_target_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o,
  output logic ia_o
);

  trig_mode_e mode;
  logic       src_q;
  logic       trig;
  logic       ip_q;
  logic       ia_q;

  assign mode = trig_mode_e'(le_i);

  always_comb begin
    trig = src_i;
    if (mode == TRIG_EDGE) begin
      trig = src_i & ~src_q;
    end
  end

  // Claim is only issued while pending and complete only while in service,
  // so the two never target this source in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= 1'b0;
      ip_q  <= 1'b0;
      ia_q  <= 1'b0;
    end else begin
      src_q <= src_i;
      if (claim_i) begin
        ip_q <= 1'b0;
        ia_q <= 1'b1;
      end else begin
        if (trig && !ip_q && !ia_q) begin
          ip_q <= 1'b1;
        end
        if (complete_i) begin
          ia_q <= 1'b0;
        end
      end
    end
  end

  assign ip_o = ip_q;
  assign ia_o = ia_q;

endmodule

`default_nettype wire

// File: rtl/prim_intr_target.sv
// +--------------------------------------------------------------------+
// | prim_intr_target: interrupt gateways, priority arbiter, claim/complete |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module prim_intr_target
  import prim_intr_target_pkg::*;
#(
  parameter  int NumSrc = 8,
  parameter  int PrioW  = 2,
  localparam int IdW    = id_width(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       intr_src_i,
  input  logic [NumSrc-1:0]       le_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_re_i,
  output logic [IdW-1:0]          claim_id_o,
  input  logic                    complete_we_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic [NumSrc-1:0]       ip_o,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o
);

  logic [NumSrc-1:0] ip;
  logic [NumSrc-1:0] ia;
  logic [NumSrc-1:0] claim_vec;
  logic [NumSrc-1:0] complete_vec;
  logic [IdW-1:0]    win_id;
  logic [PrioW-1:0]  win_prio;
  logic [IdW-1:0]    irq_id_q;
  logic [PrioW-1:0]  irq_prio_q;

  // Strict '>' starting from zero excludes prio 0 and keeps the lowest ID on ties.
  always_comb begin
    win_id   = IdW'(ID_NONE);
    win_prio = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (ip[i] && ie_i[i] && (prio_i[i*PrioW +: PrioW] > win_prio)) begin
        win_prio = prio_i[i*PrioW +: PrioW];
        win_id   = IdW'(i + 1);
      end
    end
  end

  // A stale registered ID whose pending bit is already gone decodes to nothing.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < NumSrc; i++) begin
      claim_vec[i]    = claim_re_i && (irq_id_q == IdW'(i + 1)) && ip[i];
      complete_vec[i] = complete_we_i && (complete_id_i == IdW'(i + 1)) && ia[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_id_q   <= IdW'(ID_NONE);
      irq_prio_q <= '0;
    end else begin
      irq_id_q   <= win_id;
      irq_prio_q <= win_prio;
    end
  end

  generate
    for (genvar i = 0; i < NumSrc; i++) begin : g_gateway
      prim_intr_gateway u_gateway (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .src_i      (intr_src_i[i]),
        .le_i       (le_i[i]),
        .claim_i    (claim_vec[i]),
        .complete_i (complete_vec[i]),
        .ip_o       (ip[i]),
        .ia_o       (ia[i])
      );
    end
  endgenerate

  assign ip_o       = ip;
  assign irq_o      = (irq_prio_q > threshold_i);
  assign irq_id_o   = irq_id_q;
  assign claim_id_o = claim_re_i ? irq_id_q : IdW'(ID_NONE);

endmodule

`default_nettype wire

// File: doc/prim_intr_target.md
PRIM_INTR_TARGET -- requirements
Module: prim_intr_target

Interface
REQ-001 SHALL have parameter NumSrc, default 8: number of interrupt sources (1..63).
REQ-002 SHALL have parameter PrioW, default 2: priority field width.
REQ-003 SHALL have localparam IdW = $clog2(NumSrc+1); ID 0 = "no interrupt", source i maps to ID i+1.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 intr_src_i  input  NumSrc  source lines from peripheral intr_o outputs, synchronous to clk_i.
REQ-007 le_i  input  NumSrc  per-source mode: 1 = edge (rising), 0 = level.
REQ-008 ie_i  input  NumSrc  per-source enable.
REQ-009 prio_i  input  NumSrc*PrioW  packed priorities, source i at [i*PrioW +: PrioW]; 0 = never interrupts.
REQ-010 threshold_i  input  PrioW  target threshold.
REQ-011 claim_re_i  input  1  single-cycle claim strobe.
REQ-012 claim_id_o  output  IdW  ID returned by the claim, valid in the claim_re_i cycle.
REQ-013 complete_we_i  input  1  single-cycle completion strobe.
REQ-014 complete_id_i  input  IdW  ID being completed.
REQ-015 ip_o  output  NumSrc  pending bits.
REQ-016 irq_o  output  1  interrupt request to core.
REQ-017 irq_id_o  output  IdW  current winning ID.

Function
REQ-018 Per source, the block SHALL hold a pending bit ip and an in-service bit ia; ip and ia SHALL never both be 1.
REQ-019 Level mode: ip SHALL set at the edge where intr_src_i=1, ip=0, ia=0.
REQ-020 Edge mode: ip SHALL set at the edge where intr_src_i=1 and the registered previous sample=0, with ip=0 and ia=0; edges arriving while ip or ia=1 SHALL be dropped.
REQ-021 Arbitration SHALL be combinational over ip & ie_i with prio>0: highest priority wins, ties go to lowest ID.
REQ-022 irq_id_o and the winner priority SHALL be registered; irq_o = (registered winner prio > threshold_i), updated one cycle after ip changes.
REQ-023 Latency: source high sampled at edge k -> ip_o=1 after edge k, irq_o/irq_id_o valid after edge k+1.
REQ-024 claim_id_o SHALL equal irq_id_o when claim_re_i=1, else 0.
REQ-025 Claim with irq_id_o=N!=0 SHALL clear ip[N-1] and set ia[N-1] at the next edge; claim with ID 0 SHALL have no effect.
REQ-026 Complete with complete_id_i=N, 1<=N<=NumSrc and ia[N-1]=1 SHALL clear ia[N-1] at the next edge; any other ID SHALL be ignored.
REQ-027 A level source still high after completion SHALL re-pend at the edge after ia clears.
REQ-028 Simultaneous claim of ID A and complete of ID B SHALL both take effect; A=B cannot occur (ip/ia exclusive) and needs no handling.
REQ-029 Disabling ie_i SHALL not clear ip; a masked pending interrupt reasserts when re-enabled.
REQ-030 Claim in the cycle irq_id_o is stale (ip already cleared) SHALL return the registered ID and be a no-op on cleared bits.

Reset
REQ-031 On rst_ni=0, ip, ia, edge-sample registers, irq_id_o SHALL clear to 0 asynchronously; irq_o=0, claim_id_o=0, ip_o=0.
REQ-032 Reset SHALL abort any in-service state; no completion needed after reset.

Structure
REQ-033 Package prim_intr_target_pkg SHALL hold IdW function and ID_NONE constant.
REQ-034 Per-source ip/ia/edge logic SHALL be sub-module prim_intr_gateway, instantiated NumSrc times.

Verification
REQ-035 Level src 2 (ID 3), prio 2, threshold 0, ie=1: assert at edge k -> ip_o[2]=1 after k, irq_o=1, irq_id_o=3 after k+1.
REQ-036 Sources 1 and 4 both pending, prio 1 and 3 -> irq_id_o=5; claim returns 5; next winner 2.
REQ-037 Equal prio 2 on sources 0 and 3 -> irq_id_o=1 (lowest ID wins).
REQ-038 Edge src 0, three pulses while ia=1 -> ip stays 0; after complete ID 1, no re-pend.
REQ-039 Level src held high: claim ID -> complete ID -> ip re-sets one edge later; complete with ID 0 or 9 ignored.
REQ-040 Prio 1, threshold 1 -> irq_o=0 with ip_o=1; threshold 0 -> irq_o=1 next cycle; rst_ni low mid-service -> all outputs 0.
